// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin pick helper for the N-client memory arbiter.
package mem_arb_pkg;

  localparam int MAX_CLIENTS = 8;
  localparam int MAX_IDX_W   = 3;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr, wrapping modulo n. Offsets are scanned
  // from the far end so the closest requester is the last one written.
  function automatic rr_pick_t rr_pick(input logic [MAX_CLIENTS-1:0] req,
                                       input logic [MAX_IDX_W-1:0]   ptr,
                                       input int                     n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int off = MAX_CLIENTS - 1; off >= 0; off--) begin
      if (off < n) begin
        j = int'(ptr) + off;
        if (j >= n) j = j - n;
        if (req[j[MAX_IDX_W-1:0]]) begin
          r.valid = 1'b1;
          r.idx   = j[MAX_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_tagq.sv
// In-order read tag FIFO: remembers which client issued each outstanding read.
module mem_arb_tagq #(
  parameter  int W     = 2,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     slots_q [DEPTH];
  logic [W-1:0]     slots_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = slots_q[rd_ptr_q];
  assign count = count_q;

  // Pointer/count update; a pop frees the slot a same-cycle push may take when full.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    slots_d  = slots_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      slots_d[wr_ptr_q] = push_data;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; only pointers and count are flushed.
  always_ff @(posedge clk) begin
    slots_q <= slots_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_arb_rr.sv
// Round-robin N-client arbiter onto a single Avalon-style SRAM port, with
// in-order steering of returned read words back to the issuing client.
module mem_arb_rr #(
  parameter  int NUM_CLIENTS     = 4,
  parameter  int ADDR_W          = 20,
  parameter  int DATA_W          = 16,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int BE_W            = DATA_W / 8,
  localparam int IDX_W           = $clog2(NUM_CLIENTS),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [BE_W-1:0]               mem_byteenable,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [DATA_W-1:0]             mem_writedata,
  input  logic                          mem_waitrequest,
  input  logic [DATA_W-1:0]             mem_readdata,
  input  logic                          mem_readdataready,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_address,
  input  logic [NUM_CLIENTS*BE_W-1:0]   cli_byteenable,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_writedata,
  input  logic [NUM_CLIENTS-1:0]        cli_read,
  input  logic [NUM_CLIENTS-1:0]        cli_write,
  output logic [NUM_CLIENTS-1:0]        cli_waitrequest,
  output logic [DATA_W-1:0]             cli_readdata,
  output logic [NUM_CLIENTS-1:0]        cli_readdataready,
  output logic [CNT_W-1:0]              outstanding,
  output logic                          err_orphan
);
  import mem_arb_pkg::*;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_orphan_q, err_orphan_d;

  logic [MAX_CLIENTS-1:0] req_ext;
  rr_pick_t               pick;
  logic                   busy, pop, push, read_block, complete;
  logic                   q_full, q_empty;
  logic [IDX_W-1:0]       q_head;
  logic [ADDR_W-1:0]      sel_addr;
  logic [BE_W-1:0]        sel_be;
  logic [DATA_W-1:0]      sel_wdata;

  assign req_ext   = MAX_CLIENTS'(cli_read | cli_write);
  assign pick      = rr_pick(req_ext, MAX_IDX_W'(rr_ptr_q), NUM_CLIENTS);
  assign busy      = (state_q == BUSY);
  assign sel_addr  = cli_address[grant_q*ADDR_W +: ADDR_W];
  assign sel_be    = cli_byteenable[grant_q*BE_W +: BE_W];
  assign sel_wdata = cli_writedata[grant_q*DATA_W +: DATA_W];

  // Memory-side handshake; a full tag queue stalls a read unless a word returns this cycle.
  always_comb begin
    pop        = mem_readdataready & ~q_empty;
    read_block = busy & is_rd_q & q_full & ~pop;
    mem_read   = busy & is_rd_q & ~read_block;
    mem_write  = busy & ~is_rd_q;
    complete   = (mem_read | mem_write) & ~mem_waitrequest;
    push       = complete & is_rd_q;
  end

  // Data lines follow the granted slice while busy and hold their last value in IDLE.
  always_comb begin
    mem_address    = busy ? sel_addr  : addr_q;
    mem_byteenable = busy ? sel_be    : be_q;
    mem_writedata  = busy ? sel_wdata : wdata_q;
  end

  // Client-side handshake and return steering.
  always_comb begin
    cli_waitrequest   = '1;
    cli_readdataready = '0;
    if (busy) cli_waitrequest[grant_q] = mem_waitrequest | read_block;
    if (pop)  cli_readdataready[q_head] = 1'b1;
  end

  assign cli_readdata = mem_readdata;
  assign err_orphan   = err_orphan_q;

  // IDLE/BUSY next state: grant in IDLE, release and advance the pointer on completion.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    is_rd_d      = is_rd_q;
    addr_d       = busy ? sel_addr  : addr_q;
    be_d         = busy ? sel_be    : be_q;
    wdata_d      = busy ? sel_wdata : wdata_q;
    err_orphan_d = err_orphan_q | (mem_readdataready & q_empty);
    case (state_q)
      IDLE: if (pick.valid) begin
        grant_d = IDX_W'(pick.idx);
        is_rd_d = cli_read[grant_d];
        state_d = BUSY;
      end
      BUSY: if (complete) begin
        state_d  = IDLE;
        rr_ptr_d = (grant_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      is_rd_q      <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      is_rd_q      <= is_rd_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  mem_arb_tagq #(.W(IDX_W), .DEPTH(MAX_OUTSTANDING)) u_tagq (
    .clk       (clock),
    .rst       (reset),
    .push      (push),
    .push_data (grant_q),
    .pop       (pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (outstanding)
  );

endmodule

// File: tb/tb_mem_arb_rr.sv
// Scoreboard bench for mem_arb_rr: expected memory transactions and returned
// words are queued as requests are driven and retired as the DUT produces them.
module tb_mem_arb_rr;

  localparam int NC = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = DW / 8;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [AW-1:0]    mem_address;
  logic [BW-1:0]    mem_byteenable;
  logic             mem_read, mem_write;
  logic [DW-1:0]    mem_writedata;
  logic             mem_waitrequest;
  logic [DW-1:0]    mem_readdata;
  logic             mem_readdataready;
  logic [NC*AW-1:0] cli_address;
  logic [NC*BW-1:0] cli_byteenable;
  logic [NC*DW-1:0] cli_writedata;
  logic [NC-1:0]    cli_read, cli_write;
  logic [NC-1:0]    cli_waitrequest;
  logic [DW-1:0]    cli_readdata;
  logic [NC-1:0]    cli_readdataready;
  logic [CW-1:0]    outstanding;
  logic             err_orphan;

  mem_arb_rr #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clock(clock), .reset(reset),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdataready(mem_readdataready),
    .cli_address(cli_address), .cli_byteenable(cli_byteenable),
    .cli_writedata(cli_writedata), .cli_read(cli_read), .cli_write(cli_write),
    .cli_waitrequest(cli_waitrequest), .cli_readdata(cli_readdata),
    .cli_readdataready(cli_readdataready), .outstanding(outstanding),
    .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wd; } cmp_t;
  typedef struct { logic [NC-1:0] oh; logic [DW-1:0] d; } ret_t;

  cmp_t exp_cmp[$];
  ret_t exp_ret[$];
  int   total = 0;
  int   bad   = 0;
  int   ncomp = 0;
  int   wql[NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_cli(input int i, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    cli_read[i]                = rd;
    cli_write[i]               = wr;
    cli_address[i*AW +: AW]    = a;
    cli_writedata[i*DW +: DW]  = wd;
    cli_byteenable[i*BW +: BW] = '1;
  endtask

  // One clock: observe mid-cycle, retire scoreboard entries, then drop the
  // requests of clients whose transfer completes on the coming edge.
  task automatic cyc();
    logic [NC-1:0] done;
    cmp_t c;
    ret_t r;
    @(negedge clock);
    if ((mem_read | mem_write) && !mem_waitrequest) begin
      ncomp++;
      if (exp_cmp.size() == 0) chk("cmp_extra", {mem_read, mem_write}, 2'b00);
      else begin
        c = exp_cmp.pop_front();
        chk("cmp_addr", mem_address, c.addr);
        chk("cmp_wr", mem_write, c.wr);
        if (c.wr) chk("cmp_wdata", mem_writedata, c.wd);
      end
    end
    if (cli_readdataready != '0) begin
      if (exp_ret.size() == 0) chk("ret_extra", cli_readdataready, '0);
      else begin
        r = exp_ret.pop_front();
        chk("ret_oh", cli_readdataready, r.oh);
        chk("ret_data", cli_readdata, r.d);
      end
    end
    for (int i = 0; i < NC; i++) if (!cli_waitrequest[i]) wql[i]++;
    done = (cli_read | cli_write) & ~cli_waitrequest;
    @(posedge clock);
    #1;
    cli_read  = cli_read & ~done;
    cli_write = cli_write & ~done;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((cli_read | cli_write) != '0 && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, cli_read | cli_write, '0);
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    mem_readdata      = d;
    mem_readdataready = 1'b1;
    cyc();
    mem_readdataready = 1'b0;
  endtask

  task automatic clr_cnt();
    ncomp = 0;
    for (int i = 0; i < NC; i++) wql[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdataready = 1'b0;
    cli_address = '0; cli_byteenable = '0; cli_writedata = '0;
    cli_read = '0; cli_write = '0;
    clr_cnt();

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rd", mem_read, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_be", mem_byteenable, 0);
    chk("rst_wd", mem_writedata, 0);
    chk("rst_wq", cli_waitrequest, 4'hF);
    chk("rst_rdr", cli_readdataready, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_orph", err_orphan, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // single client, two writes, zero-wait memory
    clr_cnt();
    set_cli(2, 0, 1, 20'h00010, 16'h1111);
    exp_cmp.push_back('{20'h00010, 1'b1, 16'h1111});
    drain("t1_w1", 20);
    set_cli(2, 0, 1, 20'h00004, 16'h2222);
    exp_cmp.push_back('{20'h00004, 1'b1, 16'h2222});
    drain("t1_w2", 20);
    chk("t1_ncomp", ncomp, 2);
    chk("t1_wq2_low", wql[2], 2);
    cyc();
    chk("t1_idle_hold", mem_address, 20'h00004);
    // rr_ptr should now be 3: client 3 beats client 0
    set_cli(0, 0, 1, 20'h00A00, 16'h0A0A);
    set_cli(3, 0, 1, 20'h00A03, 16'h3A3A);
    exp_cmp.push_back('{20'h00A03, 1'b1, 16'h3A3A});
    exp_cmp.push_back('{20'h00A00, 1'b1, 16'h0A0A});
    drain("t1_ptr", 30);

    // four simultaneous reads from pointer 0
    do_reset();
    clr_cnt();
    for (int i = 0; i < NC; i++) begin
      set_cli(i, 1, 0, AW'(20'h100 + i), '0);
      exp_cmp.push_back('{AW'(20'h100 + i), 1'b0, '0});
    end
    drain("t2_rd", 40);
    chk("t2_ncomp", ncomp, 4);
    chk("t2_out4", outstanding, 4);
    for (int k = 0; k < NC; k++) begin
      logic [NC-1:0] oh;
      oh = NC'(1) << k;
      exp_ret.push_back('{oh, DW'(16'hA0 + k)});
      pulse(DW'(16'hA0 + k));
    end
    chk("t2_out0", outstanding, 0);

    // fifth read blocks on a full tag queue until the first return
    for (int i = 0; i < NC; i++) begin
      set_cli(i, 1, 0, AW'(20'h200 + i), '0);
      exp_cmp.push_back('{AW'(20'h200 + i), 1'b0, '0});
    end
    drain("t3_fill", 40);
    chk("t3_out4", outstanding, 4);
    set_cli(0, 1, 0, 20'h00300, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t3_blk_rd", mem_read, 0);
      chk("t3_blk_wq", cli_waitrequest[0], 1);
      chk("t3_blk_out", outstanding, 4);
      @(posedge clock); #1;
    end
    exp_cmp.push_back('{20'h00300, 1'b0, '0});
    exp_ret.push_back('{4'b0001, 16'h00B0});
    pulse(16'h00B0);
    chk("t3_done", cli_read[0], 0);
    chk("t3_out_keep", outstanding, 4);
    exp_ret.push_back('{4'b0010, 16'h00C1}); pulse(16'h00C1);
    exp_ret.push_back('{4'b0100, 16'h00C2}); pulse(16'h00C2);
    exp_ret.push_back('{4'b1000, 16'h00C3}); pulse(16'h00C3);
    exp_ret.push_back('{4'b0001, 16'h00C0}); pulse(16'h00C0);
    chk("t3_out0", outstanding, 0);

    // stalled write on client 1 while client 0 waits its turn
    clr_cnt();
    mem_waitrequest = 1'b1;
    set_cli(1, 0, 1, 20'h00041, 16'h1234);
    set_cli(0, 0, 1, 20'h00040, 16'h5678);
    exp_cmp.push_back('{20'h00041, 1'b1, 16'h1234});
    exp_cmp.push_back('{20'h00040, 1'b1, 16'h5678});
    repeat (4) cyc();
    chk("t4_stall_req", cli_write[1:0], 2'b11);
    chk("t4_stall_comp", ncomp, 0);
    mem_waitrequest = 1'b0;
    drain("t4_drain", 20);
    chk("t4_wq0_low", wql[0], 1);
    chk("t4_wq1_low", wql[1], 1);

    // orphan return
    chk("t5_pre", err_orphan, 0);
    pulse(16'hDEAD);
    chk("t5_set", err_orphan, 1);
    repeat (3) cyc();
    chk("t5_sticky", err_orphan, 1);

    // reset with two reads in flight and a third granted
    set_cli(1, 1, 0, 20'h00501, '0);
    set_cli(2, 1, 0, 20'h00502, '0);
    exp_cmp.push_back('{20'h00501, 1'b0, '0});
    exp_cmp.push_back('{20'h00502, 1'b0, '0});
    drain("t6_rd", 20);
    chk("t6_out2", outstanding, 2);
    mem_waitrequest = 1'b1;
    set_cli(3, 1, 0, 20'h00503, '0);
    cyc();
    @(negedge clock);
    chk("t6_busy", mem_read, 1);
    reset = 1'b1;
    cli_read[3] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t6_out0", outstanding, 0);
    chk("t6_wq", cli_waitrequest, 4'hF);
    chk("t6_rd0", mem_read, 0);
    chk("t6_orph_clr", err_orphan, 0);
    @(posedge clock); #1;
    mem_waitrequest = 1'b0;
    pulse(16'hBEEF);
    chk("t6_orph", err_orphan, 1);

    chk("sb_left", exp_cmp.size() + exp_ret.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
